// File: rtl/pipe_ctrl_seq_pkg.sv
// Shared pipeline-control definitions: reset/zero constants, stall bit map,
// stall encodings and sequencer state codes.
package pipe_ctrl_seq_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam int CNT_W_DEF = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_ID_HOLD = 6'b000111;
  localparam logic [5:0] STALL_EX_HOLD = 6'b001111;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pipe_ctrl_seq.sv
// Pipeline sequencing controller: merges ID stall, multi-cycle EX hold and flush.
// Optional macro PIPE_STALL_CNT_EN adds a saturating stalled-cycle counter output.
module pipe_ctrl_seq
  import pipe_ctrl_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_start,
  input  logic [CNT_W-1:0]   ex_cycles,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               ex_busy_o,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]        stall_cycles_o,
`endif
  output logic               ex_done_o
);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_d;
  logic               flush_d;
  logic               done_d;

  // cnt_q holds the remaining EX cycles including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = STALL_W'(STALL_NONE);
    flush_d = 1'b0;
    done_d  = 1'b0;
    if (flush_req) begin
      flush_d = 1'b1;
      state_d = SEQ_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (ex_start) begin
            if (ex_cycles <= CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              stall_d = STALL_W'(STALL_EX_HOLD);
              state_d = SEQ_BUSY;
              cnt_d   = ex_cycles - CNT_W'(1);
            end
          end
        end
        SEQ_BUSY: begin
          if (cnt_q > CNT_W'(1)) begin
            stall_d = STALL_W'(STALL_EX_HOLD);
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            done_d  = 1'b1;
            state_d = SEQ_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = SEQ_IDLE;
          cnt_d   = '0;
        end
      endcase
      // ID stall is masked by the EX hold and resurfaces once it releases.
      if (stallreq_id && (stall_d == STALL_W'(STALL_NONE)))
        stall_d = STALL_W'(STALL_ID_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o   = rst ? '0   : stall_d;
  assign flush_o   = rst ? 1'b0 : flush_d;
  assign ex_done_o = rst ? 1'b0 : done_d;
  assign ex_busy_o = !rst && (state_q == SEQ_BUSY);

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable)
      stall_cycles_q <= ZeroWord;
    else if ((stall_o != '0) && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq: expected outputs queued per driven cycle,
// checked on the falling edge of the same cycle.
module tb_pipe_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id;
  logic       ex_start;
  logic [5:0] ex_cycles;
  logic       flush_req;
  logic [5:0] stall_o;
  logic       flush_o;
  logic       ex_busy_o;
  logic       ex_done_o;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  e;
  logic [31:0] exp_scnt = 32'd0;

  localparam logic [5:0] EXH = 6'b001111;
  localparam logic [5:0] IDH = 6'b000111;
  localparam logic [5:0] NON = 6'b000000;

  always #5 clk = ~clk;

  pipe_ctrl_seq dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .ex_start       (ex_start),
    .ex_cycles      (ex_cycles),
    .flush_req      (flush_req),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .ex_busy_o      (ex_busy_o),
`ifdef PIPE_STALL_CNT_EN
    .stall_cycles_o (stall_cycles_o),
`endif
    .ex_done_o      (ex_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus plus the outputs it must produce.
  task automatic step(input string name, input logic r, input logic sreq,
                      input logic st, input logic [5:0] n, input logic fl,
                      input logic [5:0] x_stall, input logic x_flush,
                      input logic x_busy, input logic x_done);
    exp_t x;
    @(posedge clk);
    #1;
    rst         = r;
    stallreq_id = sreq;
    ex_start    = st;
    ex_cycles   = n;
    flush_req   = fl;
    x.name  = name;
    x.rst   = r;
    x.stall = x_stall;
    x.flush = x_flush;
    x.busy  = x_busy;
    x.done  = x_done;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.name, ".stall"}, 32'(stall_o),   32'(e.stall));
      chk({e.name, ".flush"}, 32'(flush_o),   32'(e.flush));
      chk({e.name, ".busy"},  32'(ex_busy_o), 32'(e.busy));
      chk({e.name, ".done"},  32'(ex_done_o), 32'(e.done));
`ifdef PIPE_STALL_CNT_EN
      if (!e.rst) chk({e.name, ".scnt"}, stall_cycles_o, exp_scnt);
`endif
      if (e.rst)
        exp_scnt = 32'd0;
      else if (e.stall != NON && exp_scnt != 32'hFFFF_FFFF)
        exp_scnt = exp_scnt + 32'd1;
    end
  end

  always @(posedge clk) begin
    if (!rst)
      assert (!(ex_busy_o && ex_start)) else $error("ex_start asserted while BUSY");
  end

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0; ex_cycles = '0; flush_req = 1'b0;

    //        name     rst sreq st  n    fl    stall flush busy done
    step("rst0",  1, 0, 1, 6'd5, 0, NON, 0, 0, 0);
    step("rst1",  1, 0, 1, 6'd5, 0, NON, 0, 0, 0);
    step("idle",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("n4c0",  0, 0, 1, 6'd4, 0, EXH, 0, 0, 0);
    step("n4c1",  0, 0, 0, 6'd0, 0, EXH, 0, 1, 0);
    step("n4c2",  0, 0, 0, 6'd0, 0, EXH, 0, 1, 0);
    step("n4c3",  0, 0, 0, 6'd0, 0, NON, 0, 1, 1);
    step("n4c4",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("n1c0",  0, 0, 1, 6'd1, 0, NON, 0, 0, 1);
    step("n1c1",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);
    step("n0c0",  0, 0, 1, 6'd0, 0, NON, 0, 0, 1);
    step("n0c1",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("n2c0",  0, 0, 1, 6'd2, 0, EXH, 0, 0, 0);
    step("n2c1",  0, 0, 0, 6'd0, 0, NON, 0, 1, 1);
    step("n2c2",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("idc0",  0, 1, 1, 6'd3, 0, EXH, 0, 0, 0);
    step("idc1",  0, 1, 0, 6'd0, 0, EXH, 0, 1, 0);
    step("idc2",  0, 1, 0, 6'd0, 0, IDH, 0, 1, 1);
    step("idc3",  0, 1, 0, 6'd0, 0, IDH, 0, 0, 0);
    step("idc4",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("flc0",  0, 0, 1, 6'd6, 0, EXH, 0, 0, 0);
    step("flc1",  0, 0, 0, 6'd0, 0, EXH, 0, 1, 0);
    step("flc2",  0, 1, 0, 6'd0, 1, NON, 1, 1, 0);
    step("flc3",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);
    step("flc4",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);
    step("flc5",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("fsc0",  0, 0, 1, 6'd5, 1, NON, 1, 0, 0);
    step("fsc1",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);
    step("f1c0",  0, 0, 1, 6'd1, 1, NON, 1, 0, 0);

    step("n63c0", 0, 0, 1, 6'd63, 0, EXH, 0, 0, 0);
    for (int i = 1; i < 62; i++)
      step("n63hold", 0, 0, 0, 6'd0, 0, EXH, 0, 1, 0);
    step("n63end", 0, 0, 0, 6'd0, 0, NON, 0, 1, 1);
    step("n63aft", 0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    step("rbc0",  0, 0, 1, 6'd5, 0, EXH, 0, 0, 0);
    step("rbc1",  0, 0, 0, 6'd0, 0, EXH, 0, 1, 0);
    step("rbc2",  1, 1, 0, 6'd0, 1, NON, 0, 0, 0);
    step("rbc3",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);
    step("rbc4",  0, 1, 0, 6'd0, 0, IDH, 0, 0, 0);
    step("rbc5",  0, 0, 0, 6'd0, 0, NON, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

endmodule
